// File: rtl/conv2d_pe_sequencer_if.sv
// Handshake bundle between the layer sequencer, the AXI-Lite control block and the PE CU.
// The sequencer takes the master side and the surrounding logic takes the slave side.
interface conv2d_pe_sequencer_if #(
    parameter int CH_W  = 8,
    parameter int ROW_W = 9
);
    logic             start;
    logic [CH_W-1:0]  cfg_num_in_ch;
    logic [CH_W-1:0]  cfg_num_out_ch;
    logic [ROW_W-1:0] cfg_num_rows;
    logic             kernel_valid;
    logic             row_valid;
    logic             PE_ready;
    logic             PE_with_buffers_IDLE;
    logic             busy;
    logic             done;
    logic             pe_rst_n;
    logic             Load_kernel_reg;
    logic             Stream_mid_row;
    logic             Stream_last_row;
    logic             last_channel;
    logic [CH_W-1:0]  b_counter_output;
    logic [CH_W-1:0]  out_ch_idx;
    logic [ROW_W-1:0] row_idx;
    logic             kernel_req;
    logic             bias_addr_inc;

    modport master (
        input  start, cfg_num_in_ch, cfg_num_out_ch, cfg_num_rows,
        input  kernel_valid, row_valid, PE_ready, PE_with_buffers_IDLE,
        output busy, done, pe_rst_n, Load_kernel_reg, Stream_mid_row, Stream_last_row,
        output last_channel, b_counter_output, out_ch_idx, row_idx, kernel_req, bias_addr_inc
    );

    modport slave (
        output start, cfg_num_in_ch, cfg_num_out_ch, cfg_num_rows,
        output kernel_valid, row_valid, PE_ready, PE_with_buffers_IDLE,
        input  busy, done, pe_rst_n, Load_kernel_reg, Stream_mid_row, Stream_last_row,
        input  last_channel, b_counter_output, out_ch_idx, row_idx, kernel_req, bias_addr_inc
    );
endinterface

// File: rtl/conv2d_pe_sequencer.sv
// Layer scheduler for the PE CU: walks output channels, input channels and rows,
// issuing kernel loads and row streams with all outputs registered.
module conv2d_pe_sequencer #(
    parameter int CH_W  = 8,
    parameter int ROW_W = 9
) (
    input logic clk,
    input logic Reset,
    conv2d_pe_sequencer_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_PE_RST, S_WAIT_IDLE, S_REQ_KERNEL, S_ENTER_LAST, S_WAIT_KERNEL,
        S_WAIT_READY, S_WAIT_ROW, S_WAIT_ROW_DONE, S_NEXT_CH, S_DONE
    } state_t;

    localparam logic [CH_W-1:0]  CH_ONE  = 1;
    localparam logic [ROW_W-1:0] ROW_ONE = 1;

    state_t           state;
    logic [CH_W-1:0]  num_in_ch;
    logic [CH_W-1:0]  num_out_ch;
    logic [ROW_W-1:0] num_rows;
    logic             settle;
    logic             is_last_in;
    logic             is_last_out;
    logic             is_last_row;
    logic             cfg_zero;

    assign is_last_in  = (bus.b_counter_output == num_in_ch - CH_ONE);
    assign is_last_out = (bus.out_ch_idx == num_out_ch - CH_ONE);
    assign is_last_row = (bus.row_idx == num_rows - ROW_ONE);
    assign cfg_zero    = (bus.cfg_num_in_ch == '0) || (bus.cfg_num_out_ch == '0) ||
                         (bus.cfg_num_rows == '0);

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state                <= S_IDLE;
            num_in_ch            <= '0;
            num_out_ch           <= '0;
            num_rows             <= '0;
            settle               <= 1'b0;
            bus.busy             <= 1'b0;
            bus.done             <= 1'b0;
            bus.pe_rst_n         <= 1'b0;
            bus.Load_kernel_reg  <= 1'b0;
            bus.Stream_mid_row   <= 1'b0;
            bus.Stream_last_row  <= 1'b0;
            bus.last_channel     <= 1'b0;
            bus.b_counter_output <= '0;
            bus.out_ch_idx       <= '0;
            bus.row_idx          <= '0;
            bus.kernel_req       <= 1'b0;
            bus.bias_addr_inc    <= 1'b0;
        end else begin
            bus.done            <= 1'b0;
            bus.pe_rst_n        <= 1'b1;
            bus.Load_kernel_reg <= 1'b0;
            bus.Stream_mid_row  <= 1'b0;
            bus.Stream_last_row <= 1'b0;
            bus.kernel_req      <= 1'b0;
            bus.bias_addr_inc   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (cfg_zero) begin
                            state <= S_DONE;
                        end else begin
                            num_in_ch    <= bus.cfg_num_in_ch;
                            num_out_ch   <= bus.cfg_num_out_ch;
                            num_rows     <= bus.cfg_num_rows;
                            bus.busy     <= 1'b1;
                            bus.pe_rst_n <= 1'b0;
                            state        <= S_PE_RST;
                        end
                    end
                end
                S_PE_RST: state <= S_WAIT_IDLE;
                S_WAIT_IDLE: begin
                    if (bus.PE_with_buffers_IDLE) begin
                        bus.kernel_req <= 1'b1;
                        state          <= S_REQ_KERNEL;
                    end
                end
                S_REQ_KERNEL: begin
                    if (is_last_in) begin
                        bus.last_channel <= 1'b1;
                        state            <= S_ENTER_LAST;
                    end else begin
                        state <= S_WAIT_KERNEL;
                    end
                end
                // Quiet cycle lets the CU settle into its last-channel idle first.
                S_ENTER_LAST: state <= S_WAIT_KERNEL;
                S_WAIT_KERNEL: begin
                    if (bus.kernel_valid && bus.PE_with_buffers_IDLE) begin
                        bus.Load_kernel_reg <= 1'b1;
                        state               <= S_WAIT_READY;
                    end
                end
                S_WAIT_READY: begin
                    if (bus.PE_ready && !bus.Load_kernel_reg) state <= S_WAIT_ROW;
                end
                S_WAIT_ROW: begin
                    if (bus.row_valid && bus.PE_with_buffers_IDLE) begin
                        bus.Stream_last_row <= is_last_row;
                        bus.Stream_mid_row  <= !is_last_row;
                        settle              <= 1'b1;
                        state               <= S_WAIT_ROW_DONE;
                    end
                end
                // The CU still looks idle while the stream command is in flight.
                S_WAIT_ROW_DONE: begin
                    if (!(bus.Stream_mid_row || bus.Stream_last_row)) begin
                        if (settle) begin
                            settle <= 1'b0;
                        end else if (bus.PE_with_buffers_IDLE) begin
                            if (is_last_row) begin
                                bus.row_idx <= '0;
                                state       <= S_NEXT_CH;
                            end else begin
                                bus.row_idx <= bus.row_idx + ROW_ONE;
                                state       <= S_WAIT_ROW;
                            end
                        end
                    end
                end
                S_NEXT_CH: begin
                    if (!is_last_in) begin
                        bus.b_counter_output <= bus.b_counter_output + CH_ONE;
                        bus.kernel_req       <= 1'b1;
                        state                <= S_REQ_KERNEL;
                    end else begin
                        bus.b_counter_output <= '0;
                        bus.bias_addr_inc    <= 1'b1;
                        bus.last_channel     <= 1'b0;
                        if (!is_last_out) begin
                            bus.out_ch_idx <= bus.out_ch_idx + CH_ONE;
                            bus.pe_rst_n   <= 1'b0;
                            state          <= S_PE_RST;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    bus.last_channel     <= 1'b0;
                    bus.done             <= 1'b1;
                    bus.busy             <= 1'b0;
                    bus.b_counter_output <= '0;
                    bus.out_ch_idx       <= '0;
                    bus.row_idx          <= '0;
                    state                <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv2d_pe_sequencer.sv
// Directed bench for conv2d_pe_sequencer: table of layer shapes with expected pulse
// counts, plus hand sequences for zero-size layers, stalls, ordering and mid-layer reset.
module tb_conv2d_pe_sequencer;
    localparam int CH_W  = 8;
    localparam int ROW_W = 9;

    typedef struct {
        int n_in; int n_out; int n_rows;
        int loads; int mids; int lasts; int bias; int perst; int kreq; int dones;
    } vec_t;

    logic clk   = 1'b0;
    logic Reset = 1'b0;
    always #5 clk = ~clk;

    conv2d_pe_sequencer_if #(.CH_W(CH_W), .ROW_W(ROW_W)) bus ();
    conv2d_pe_sequencer #(.CH_W(CH_W), .ROW_W(ROW_W)) dut (.clk(clk), .Reset(Reset), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;

    // PE CU model: 3-cycle kernel write ending in PE_ready, 10 busy cycles per row.
    logic [3:0] kcnt = '0;
    logic [3:0] rcnt = '0;
    always @(posedge clk) begin
        if (!bus.pe_rst_n) begin
            kcnt <= '0;
            rcnt <= '0;
        end else begin
            if (bus.Load_kernel_reg) kcnt <= 4'd3;
            else if (kcnt != 0)      kcnt <= kcnt - 4'd1;
            if (bus.Stream_mid_row || bus.Stream_last_row) rcnt <= 4'd10;
            else if (rcnt != 0)                            rcnt <= rcnt - 4'd1;
        end
    end
    assign bus.PE_ready             = (kcnt == 4'd1);
    assign bus.PE_with_buffers_IDLE = (kcnt == 4'd0) && (rcnt == 4'd0);

    // Event totals: 0 load, 1 mid, 2 last, 3 bias, 4 pe_rst, 5 kreq, 6 done, 7 overlap, 8 last_channel rule
    int   cnt[9] = '{default: 0};
    int   snap[9];
    int   load_b[256];
    int   load_oc[256];
    int   n_in_cur = 0;
    int   cyc = 0;
    int   t_perst = 0, t_kreq = 0, t_lc = 0, t_load = 0, t_last = 0, t_done = 0;
    logic lc_prev = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (Reset) begin
            if (bus.Load_kernel_reg) begin
                load_b[cnt[0] & 255]  = int'(bus.b_counter_output);
                load_oc[cnt[0] & 255] = int'(bus.out_ch_idx);
                if (int'(bus.b_counter_output) == n_in_cur - 1 && !lc_prev) cnt[8]++;
                cnt[0]++;
                t_load = cyc;
            end
            if (bus.Stream_mid_row)  cnt[1]++;
            if (bus.Stream_last_row) begin cnt[2]++; t_last = cyc; end
            if (bus.bias_addr_inc)   cnt[3]++;
            if (!bus.pe_rst_n)       begin cnt[4]++; t_perst = cyc; end
            if (bus.kernel_req)      begin cnt[5]++; t_kreq = cyc; end
            if (bus.done)            begin cnt[6]++; t_done = cyc; end
            if (int'(bus.Load_kernel_reg) + int'(bus.Stream_mid_row) + int'(bus.Stream_last_row) > 1)
                cnt[7]++;
            if (bus.last_channel && !lc_prev) t_lc = cyc;
            if (bus.last_channel && int'(bus.b_counter_output) != n_in_cur - 1) cnt[8]++;
        end
        lc_prev = bus.last_channel;
    end

    function automatic int diff(input int i);
        return cnt[i] - snap[i];
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic applyStimulus(input int n_in, input int n_out, input int n_rows);
        @(negedge clk);
        snap                = cnt;
        n_in_cur            = n_in;
        bus.cfg_num_in_ch   = CH_W'(n_in);
        bus.cfg_num_out_ch  = CH_W'(n_out);
        bus.cfg_num_rows    = ROW_W'(n_rows);
        bus.start           = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (cnt[6] != snap[6]) break;
        end
        checkOutput(name, int'(k < budget), 1);
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[7];

    initial begin
        int k;
        int s_str;
        vecs[0] = '{2, 2, 3, 4, 8, 4, 2, 2, 4, 1};
        vecs[1] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
        vecs[2] = '{3, 1, 2, 3, 3, 3, 1, 1, 3, 1};
        vecs[3] = '{1, 3, 1, 3, 0, 3, 3, 3, 3, 1};
        vecs[4] = '{2, 1, 4, 2, 6, 2, 1, 1, 2, 1};
        vecs[5] = '{0, 2, 3, 0, 0, 0, 0, 0, 0, 1};
        vecs[6] = '{2, 2, 0, 0, 0, 0, 0, 0, 0, 1};

        bus.start = 1'b0; bus.kernel_valid = 1'b1; bus.row_valid = 1'b1;
        bus.cfg_num_in_ch = '0; bus.cfg_num_out_ch = '0; bus.cfg_num_rows = '0;

        repeat (3) @(negedge clk);
        checkOutput("rst_pe_rst_n", int'(bus.pe_rst_n), 0);
        checkOutput("rst_flags", int'({bus.busy, bus.done, bus.Load_kernel_reg, bus.Stream_mid_row,
                    bus.Stream_last_row, bus.last_channel, bus.kernel_req, bus.bias_addr_inc}), 0);
        checkOutput("rst_counters", int'(bus.b_counter_output) + int'(bus.out_ch_idx) + int'(bus.row_idx), 0);
        Reset = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_pe_rst_n", int'(bus.pe_rst_n), 1);

        // Zero-row layer: done shows up one cycle after the DONE state is entered.
        bus.cfg_num_in_ch = 8'd2; bus.cfg_num_out_ch = 8'd2; bus.cfg_num_rows = '0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput("zero_done_early", int'(bus.done), 0);
        checkOutput("zero_busy", int'(bus.busy), 0);
        @(posedge clk); #1;
        checkOutput("zero_done_pulse", int'(bus.done), 1);
        @(posedge clk); #1;
        checkOutput("zero_done_width", int'(bus.done), 0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].n_in, vecs[i].n_out, vecs[i].n_rows);
            wait_done($sformatf("vec%0d_done_seen", i), 3000);
            checkOutput($sformatf("vec%0d_loads", i),   diff(0), vecs[i].loads);
            checkOutput($sformatf("vec%0d_mids", i),    diff(1), vecs[i].mids);
            checkOutput($sformatf("vec%0d_lasts", i),   diff(2), vecs[i].lasts);
            checkOutput($sformatf("vec%0d_bias", i),    diff(3), vecs[i].bias);
            checkOutput($sformatf("vec%0d_pe_rst", i),  diff(4), vecs[i].perst);
            checkOutput($sformatf("vec%0d_kreq", i),    diff(5), vecs[i].kreq);
            checkOutput($sformatf("vec%0d_done", i),    diff(6), vecs[i].dones);
            checkOutput($sformatf("vec%0d_overlap", i), diff(7), 0);
            checkOutput($sformatf("vec%0d_lc_rule", i), diff(8), 0);
            checkOutput($sformatf("vec%0d_idle", i),    int'(bus.busy), 0);
        end

        // Single channel / single row: strict event order.
        applyStimulus(1, 1, 1);
        wait_done("order_done_seen", 3000);
        checkOutput("order_perst_kreq", int'(t_perst < t_kreq), 1);
        checkOutput("order_kreq_lc",    int'(t_kreq < t_lc), 1);
        checkOutput("order_lc_load",    int'(t_lc < t_load), 1);
        checkOutput("order_load_last",  int'(t_load < t_last), 1);
        checkOutput("order_last_done",  int'(t_last < t_done), 1);
        checkOutput("order_no_mid",     diff(1), 0);

        // Row stall at row 1 with a stray start in the middle.
        applyStimulus(2, 2, 3);
        for (k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (bus.row_idx == 9'd1) break;
        end
        checkOutput("stall_reach_row1", int'(k < 2000), 1);
        bus.row_valid = 1'b0;
        s_str = cnt[1] + cnt[2];
        repeat (20) @(negedge clk);
        bus.cfg_num_rows = 9'd1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (29) @(negedge clk);
        checkOutput("stall_no_stream", cnt[1] + cnt[2] - s_str, 0);
        checkOutput("stray_start_row", int'(bus.row_idx), 1);
        checkOutput("stray_start_out_ch", int'(bus.out_ch_idx), 0);
        checkOutput("stray_start_busy", int'(bus.busy), 1);
        bus.row_valid = 1'b1;
        @(negedge clk);
        checkOutput("stall_release_mid", int'(bus.Stream_mid_row), 1);
        wait_done("stall_done_seen", 3000);
        checkOutput("stall_loads", diff(0), 4);
        checkOutput("stall_mids", diff(1), 8);
        for (int j = 0; j < 4; j++)
            checkOutput($sformatf("b_seq%0d", j), load_b[(snap[0] + j) & 255], j % 2);

        // Reset in the middle of the last row of output channel 1.
        applyStimulus(2, 2, 3);
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (bus.out_ch_idx == 8'd1 && bus.row_idx == 9'd2 && !bus.PE_with_buffers_IDLE) break;
        end
        checkOutput("abort_reach_point", int'(k < 3000), 1);
        Reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_pe_rst_n", int'(bus.pe_rst_n), 0);
        checkOutput("abort_flags", int'({bus.busy, bus.done, bus.Load_kernel_reg, bus.Stream_mid_row,
                    bus.Stream_last_row, bus.last_channel, bus.kernel_req, bus.bias_addr_inc}), 0);
        checkOutput("abort_counters", int'(bus.b_counter_output) + int'(bus.out_ch_idx) + int'(bus.row_idx), 0);
        @(negedge clk);
        Reset = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("abort_no_done", diff(6), 0);
        checkOutput("abort_idle", int'(bus.busy), 0);
        applyStimulus(1, 1, 1);
        wait_done("restart_done_seen", 3000);
        checkOutput("restart_loads", diff(0), 1);
        checkOutput("restart_out_ch", load_oc[snap[0] & 255], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/conv2d_pe_sequencer.md
Name: conv2d_pe_sequencer

Overview:
- Layer-level scheduler for the PE-with-buffers control unit (PE CU) in the Conv2d datapath.
- On `start`, loops over output channels, then input channels, then rows. For each input channel it issues a kernel load; for each row it issues a row stream.
- Drives `b_counter_output` and `last_channel`, and soft-resets the PE CU between output channels so the CU's sticky last-channel mode is cleared.
- Sits between the top-level AXI-Lite control block and the PE CU.

Parameters:
- CH_W, 8, width of the channel counters and of `b_counter_output`.
- ROW_W, 9, width of the row counter.

Ports:
- clk  in  1  clock
- Reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse that begins a layer; ignored while busy=1
- cfg_num_in_ch  in  CH_W  input channels per output channel; sampled on start
- cfg_num_out_ch  in  CH_W  output channels; sampled on start
- cfg_num_rows  in  ROW_W  feature-map rows; sampled on start
- kernel_valid  in  1  kernel staging buffer holds the weights for the current channel pair
- row_valid  in  1  line buffer holds the next input row
- PE_ready  in  1  PE CU has finished the kernel write
- PE_with_buffers_IDLE  in  1  PE CU is in an idle state
- busy  out  1  a layer is in progress
- done  out  1  one-cycle pulse when the layer completes
- pe_rst_n  out  1  active-low soft reset to the PE CU
- Load_kernel_reg  out  1  one-cycle kernel-load command
- Stream_mid_row  out  1  one-cycle command to stream a non-final row
- Stream_last_row  out  1  one-cycle command to stream the final row
- last_channel  out  1  level signal: current input channel is the last one
- b_counter_output  out  CH_W  current input-channel index
- out_ch_idx  out  CH_W  current output-channel index
- row_idx  out  ROW_W  current row index
- kernel_req  out  1  one-cycle pulse asking the loader for the next kernel
- bias_addr_inc  out  1  one-cycle pulse that advances the bias BRAM address

Behaviour:
- Reset=0: FSM goes to S_IDLE.
  - All counters are 0.
  - pe_rst_n=0 while Reset=0, then 1.
  - All other outputs are 0.
- Outputs are registered unless stated otherwise. Command pulses are exactly 1 cycle wide.
- S_IDLE:
  - start with all cfg values nonzero: latch cfg, busy=1, go to S_PE_RST.
  - start with any cfg value equal to 0: go to S_DONE; no commands are issued.
- S_PE_RST: pe_rst_n=0 for exactly 1 cycle, then S_WAIT_IDLE.
- S_WAIT_IDLE: wait for PE_with_buffers_IDLE=1, then S_REQ_KERNEL.
- S_REQ_KERNEL:
  - kernel_req=1 for 1 cycle.
  - If b_counter_output == num_in_ch-1: go to S_ENTER_LAST. Otherwise go to S_WAIT_KERNEL.
- S_ENTER_LAST:
  - Assert last_channel. It stays high until the next pe_rst_n pulse or reset.
  - Hold for 1 cycle with no command, so the CU moves to its last-channel idle before any command arrives.
  - Then S_WAIT_KERNEL.
- S_WAIT_KERNEL: when kernel_valid=1 and PE_with_buffers_IDLE=1, pulse Load_kernel_reg, then S_WAIT_READY.
- S_WAIT_READY:
  - Wait for PE_ready=1, then S_WAIT_ROW.
  - PE_ready is accepted from the cycle after the Load_kernel_reg pulse onward.
- S_WAIT_ROW:
  - When row_valid=1 and PE_with_buffers_IDLE=1, go to S_WAIT_ROW_DONE.
  - In that same cycle, pulse Stream_last_row if row_idx == num_rows-1, else Stream_mid_row.
- S_WAIT_ROW_DONE:
  - PE_with_buffers_IDLE is ignored in the cycle right after the stream pulse.
  - After that, PE_with_buffers_IDLE=1 means the row is complete.
  - If it was not the last row: row_idx+1, back to S_WAIT_ROW.
  - If it was the last row: row_idx=0, go to S_NEXT_CH.
- S_NEXT_CH:
  - If b_counter_output < num_in_ch-1: b_counter_output+1, go to S_REQ_KERNEL.
  - Otherwise:
    - b_counter_output=0 and bias_addr_inc=1.
    - If out_ch_idx < num_out_ch-1: out_ch_idx+1, clear last_channel, go to S_PE_RST.
    - Otherwise go to S_DONE.
- S_DONE:
  - Clear last_channel.
  - done=1 for 1 cycle and busy=0.
  - Counters return to 0; go to S_IDLE.
- The stream commands and Load_kernel_reg are mutually exclusive; at most one is asserted in any cycle.
- Single input channel (num_in_ch=1): the first channel is also the last one, so the path goes directly through S_ENTER_LAST.
- Single row (num_rows=1): only Stream_last_row is issued.
- Stalls: the FSM holds indefinitely while waiting on kernel_valid, row_valid, PE_ready or PE_with_buffers_IDLE. There is no timeout.
- Reset=0 mid-layer: abort immediately. pe_rst_n is held low, so the PE CU is also reset. No done pulse is produced.

Test Plan:
- Counts 2/2/3 (in/out/rows); PE CU model with 10-cycle rows; valid inputs tied to 1:
  - 4 Load_kernel_reg pulses.
  - 8 Stream_mid_row pulses and 4 Stream_last_row pulses.
  - 2 bias_addr_inc pulses, 2 pe_rst_n pulses, then one done pulse.
- Same counts: b_counter_output sequence 0,1,0,1. last_channel is high only while b_counter_output=1, and rises at least 1 cycle before that channel's Load_kernel_reg.
- Counts 1/1/1: sequence is pe_rst_n, kernel_req, last_channel, Load_kernel_reg, Stream_last_row, done. No Stream_mid_row is issued.
- Hold row_valid=0 for 50 cycles at row 1: no stream pulse during that time; Stream_mid_row issues on the first cycle row_valid=1 and PE_with_buffers_IDLE=1.
- cfg_num_rows=0 with start: done 1 cycle after S_DONE is entered; no commands are issued. A start pulse while busy=1 has no effect on the counters.
- Reset=0 mid-row at out_ch 1 / row 2: next cycle all outputs are 0 and pe_rst_n=0; a new start restarts from out_ch 0.
